// File: rtl/product_accumulator_pkg.sv
// Shared defaults, FSM state type and width-generic helpers for the product accumulator.
// Helpers work on a 64-bit container with an explicit width argument, so ACC_W/CNT_W must stay <= 64.
package product_accumulator_pkg;
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  // Extend the low pw bits of p to 64 bits; sign-extend when s is set.
  function automatic logic [63:0] ext_prod(input logic [63:0] p, input int pw, input logic s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < pw) ? p[i] : (s & p[pw-1]);
    return r;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] c, input int w);
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    return (c == max) ? c : c + 64'd1;
  endfunction
endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Combinational extend + add + overflow detect for one accumulation step.
// SATURATE_EN: clamp on overflow and keep holding the clamped value while hold_i is set.
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              signed_i,
  input  logic              hold_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   wide;

  assign ext  = ACC_W'(ext_prod(64'(prod_i), PROD_W, signed_i));
  assign wide = {1'b0, acc_i} + {1'b0, ext};

  // Unsigned: carry out. Signed: like-signed operands producing a different sign.
  assign ovf_o = signed_i ? ((acc_i[ACC_W-1] == ext[ACC_W-1]) && (wide[ACC_W-1] != acc_i[ACC_W-1]))
                          : wide[ACC_W];

`ifdef SATURATE_EN
  always_comb begin
    sum_o = wide[ACC_W-1:0];
    if (hold_i)
      sum_o = acc_i;
    else if (ovf_o && !signed_i)
      sum_o = '1;
    else if (ovf_o)
      sum_o = acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  logic unused_hold;
  assign unused_hold = hold_i;
  assign sum_o = wide[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of products into a wide register and presents the dot product on the last beat.
// Optional SATURATE_EN macro: clamp instead of wrap on overflow (see acc_adder).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_signed,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, mode_q, mode_d;
  logic [ACC_W-1:0] sum;
  logic             add_ovf, beat, first;

  assign first = (state_q == IDLE);
  assign beat  = in_valid && in_ready;

  // The first beat adds onto zero with its own in_signed, so one adder covers both load and accumulate.
  acc_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .acc_i    (first ? '0 : acc_q),
    .prod_i   (in_prod),
    .signed_i (first ? in_signed : mode_q),
    .hold_i   (first ? 1'b0 : ovf_q),
    .sum_o    (sum),
    .ovf_o    (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (beat) begin
        mode_d  = in_signed;
        acc_d   = sum;
        cnt_d   = CNT_W'(1);
        ovf_d   = 1'b0;
        state_d = in_last ? HOLD : ACCUM;
      end
      ACCUM: if (beat) begin
        acc_d   = sum;
        cnt_d   = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
        ovf_d   = ovf_q | add_ovf;
        if (in_last) state_d = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only; out_ready never reaches in_ready.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;
endmodule
